// File: rtl/rng_ranged.sv
// ============================================================================
// Module   : rng_ranged
// Purpose  : LFSR random source with exact [MIN_VALUE, MAX_VALUE] range by
//            rejection sampling, valid/ready output register, runtime reseed.
//            Optional zero-seed guard: define RNG_ZERO_GUARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rng_ranged #(
    parameter int unsigned         WIDTH     = 10,
    parameter logic [WIDTH-1:0]    TAPS      = 10'h240,
    parameter logic [WIDTH-1:0]    SEED      = 1,
    parameter int unsigned         MIN_VALUE = 200,
    parameter int unsigned         MAX_VALUE = 1223,
    parameter int unsigned         REJ_W     = 16
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      enable,
    input  logic                                      seed_load,
    input  logic [WIDTH-1:0]                          seed_in,
    input  logic                                      out_ready,
    output logic                                      out_valid,
    output logic [$clog2(64'(MAX_VALUE) + 64'd1)-1:0] out_value,
    output logic [REJ_W-1:0]                          reject_cnt
`ifdef RNG_ZERO_GUARD_EN
    ,
    output logic                                      seed_err
`endif
);

    localparam int          OW     = $clog2(64'(MAX_VALUE) + 64'd1);
    localparam logic [32:0] RANGE  = 33'(MAX_VALUE) - 33'(MIN_VALUE) + 33'd1;
    localparam int          RB_RAW = $clog2(RANGE);
    localparam int          RBITS  = (RB_RAW < 1) ? 1 : RB_RAW;

    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic             out_valid_q, out_valid_d;
    logic [OW-1:0]    out_value_q, out_value_d;
    logic [REJ_W-1:0] reject_cnt_q, reject_cnt_d;

    logic             w_fb;
    logic [WIDTH-1:0] w_lfsr_next;
    logic [RBITS-1:0] w_cand;
    logic             w_accept;
    logic             w_free;
    logic [WIDTH-1:0] w_seed_sel;

    assign w_fb        = ^(lfsr_q & TAPS);
    assign w_lfsr_next = {lfsr_q[WIDTH-2:0], w_fb};
    assign w_cand      = lfsr_q[RBITS-1:0];
    assign w_accept    = (33'(w_cand) < RANGE);
    assign w_free      = !out_valid_q || out_ready;

`ifdef RNG_ZERO_GUARD_EN
    logic seed_err_q, seed_err_d;
    logic w_seed_zero;

    // A zero seed would lock the LFSR, so the reset seed is used instead.
    assign w_seed_zero = (seed_in == '0);
    assign w_seed_sel  = w_seed_zero ? SEED : seed_in;
    assign seed_err    = seed_err_q;
`else
    assign w_seed_sel  = seed_in;
`endif

    always_comb begin
        lfsr_d       = lfsr_q;
        out_valid_d  = out_valid_q;
        out_value_d  = out_value_q;
        reject_cnt_d = reject_cnt_q;
`ifdef RNG_ZERO_GUARD_EN
        seed_err_d   = 1'b0;
`endif
        if (seed_load) begin
            lfsr_d      = w_seed_sel;
            out_valid_d = 1'b0;
`ifdef RNG_ZERO_GUARD_EN
            seed_err_d  = w_seed_zero;
`endif
        end else if (!enable) begin
            if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
        end else begin
            // The LFSR keeps stepping under backpressure; draws are simply skipped.
            lfsr_d = w_lfsr_next;
            if (w_free) begin
                if (w_accept) begin
                    out_value_d = OW'(w_cand) + OW'(MIN_VALUE);
                    out_valid_d = 1'b1;
                end else begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                    end
                    if (reject_cnt_q != {REJ_W{1'b1}}) begin
                        reject_cnt_d = reject_cnt_q + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q       <= SEED;
            out_valid_q  <= 1'b0;
            out_value_q  <= '0;
            reject_cnt_q <= '0;
`ifdef RNG_ZERO_GUARD_EN
            seed_err_q   <= 1'b0;
`endif
        end else begin
            lfsr_q       <= lfsr_d;
            out_valid_q  <= out_valid_d;
            out_value_q  <= out_value_d;
            reject_cnt_q <= reject_cnt_d;
`ifdef RNG_ZERO_GUARD_EN
            seed_err_q   <= seed_err_d;
`endif
        end
    end

    assign out_valid  = out_valid_q;
    assign out_value  = out_value_q;
    assign reject_cnt = reject_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_rng_ranged.sv
// ============================================================================
// Module   : tb_rng_ranged
// Purpose  : Directed, table-driven bench for rng_ranged (default and small
//            range instances). Honours RNG_ZERO_GUARD_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rng_ranged;

    logic clk;
    logic reset;

    // Instance A: default parameters (range 200..1223, OW = 11)
    logic        a_en, a_sl, a_rdy, a_valid;
    logic [9:0]  a_seed;
    logic [10:0] a_value;
    logic [15:0] a_rej;
`ifdef RNG_ZERO_GUARD_EN
    logic        a_serr;
    logic        b_serr;
`endif

    // Instance B: range 0..4, 2-bit rejection counter (OW = 3)
    logic        b_en, b_sl, b_rdy, b_valid;
    logic [9:0]  b_seed;
    logic [2:0]  b_value;
    logic [1:0]  b_rej;

    int checks;
    int errors;

    rng_ranged dut_a (
        .clk        (clk),
        .reset      (reset),
        .enable     (a_en),
        .seed_load  (a_sl),
        .seed_in    (a_seed),
        .out_ready  (a_rdy),
        .out_valid  (a_valid),
        .out_value  (a_value),
        .reject_cnt (a_rej)
`ifdef RNG_ZERO_GUARD_EN
        ,
        .seed_err   (a_serr)
`endif
    );

    rng_ranged #(
        .MIN_VALUE (0),
        .MAX_VALUE (4),
        .REJ_W     (2)
    ) dut_b (
        .clk        (clk),
        .reset      (reset),
        .enable     (b_en),
        .seed_load  (b_sl),
        .seed_in    (b_seed),
        .out_ready  (b_rdy),
        .out_valid  (b_valid),
        .out_value  (b_value),
        .reject_cnt (b_rej)
`ifdef RNG_ZERO_GUARD_EN
        ,
        .seed_err   (b_serr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        en;
        logic        sl;
        logic [9:0]  seed;
        logic        rdy;
        logic        exp_valid;
        logic        chk_value;
        logic [10:0] exp_value;
    } vec_t;

    vec_t vecs[14];

    logic [1:0]  b_exp_valid [9];
    logic [2:0]  b_exp_value [9];
    logic [1:0]  b_exp_rej   [9];

    initial begin
        //            en sl seed   rdy vld chk value
        vecs[0]  = '{1, 0, 10'd0,   1, 1, 1, 11'd201};
        vecs[1]  = '{1, 0, 10'd0,   1, 1, 1, 11'd202};
        vecs[2]  = '{1, 0, 10'd0,   1, 1, 1, 11'd204};
        vecs[3]  = '{1, 0, 10'd0,   1, 1, 1, 11'd208};
        vecs[4]  = '{1, 0, 10'd0,   0, 1, 1, 11'd208};
        vecs[5]  = '{1, 0, 10'd0,   0, 1, 1, 11'd208};
        vecs[6]  = '{0, 0, 10'd0,   0, 1, 1, 11'd208};
        vecs[7]  = '{0, 0, 10'd0,   1, 0, 1, 11'd208};
        vecs[8]  = '{1, 0, 10'd0,   0, 1, 1, 11'd264};
        vecs[9]  = '{1, 0, 10'd0,   1, 1, 1, 11'd329};
        vecs[10] = '{1, 1, 10'd341, 1, 0, 0, 11'd0};
        vecs[11] = '{1, 0, 10'd0,   1, 1, 1, 11'd541};
        vecs[12] = '{1, 0, 10'd0,   1, 1, 1, 11'd883};
        vecs[13] = '{1, 0, 10'd0,   1, 1, 1, 11'd543};

        // Seed 7, range 0..4: cand 7,6 rejected, then 4,0,0,1,3, then 7,7 rejected.
        b_exp_valid = '{0, 0, 1, 1, 1, 1, 1, 0, 0};
        b_exp_value = '{0, 0, 4, 0, 0, 1, 3, 3, 3};
        b_exp_rej   = '{1, 2, 2, 2, 2, 2, 2, 3, 3};

        checks = 0;
        errors = 0;
        reset  = 1'b1;
        a_en = 0; a_sl = 0; a_seed = '0; a_rdy = 0;
        b_en = 0; b_sl = 0; b_seed = '0; b_rdy = 0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_a_valid", 32'(a_valid), 0);
        check("reset_a_value", 32'(a_value), 0);
        check("reset_a_rej",   32'(a_rej),   0);
        check("reset_b_valid", 32'(b_valid), 0);
        check("reset_b_rej",   32'(b_rej),   0);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            a_en   = vecs[i].en;
            a_sl   = vecs[i].sl;
            a_seed = vecs[i].seed;
            a_rdy  = vecs[i].rdy;
            tick();
            check($sformatf("vec%0d_valid", i), 32'(a_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].chk_value)
                check($sformatf("vec%0d_value", i), 32'(a_value), 32'(vecs[i].exp_value));
            check($sformatf("vec%0d_rej", i), 32'(a_rej), 0);
        end

        // Backpressure: hold 201 for five cycles while the LFSR keeps stepping.
        reset = 1'b1;
        #2;
        reset = 1'b0;
        a_sl = 0; a_en = 1; a_rdy = 0;
        tick();
        check("bp_first_valid", 32'(a_valid), 1);
        check("bp_first_value", 32'(a_value), 201);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("bp_hold%0d_valid", i), 32'(a_valid), 1);
            check($sformatf("bp_hold%0d_value", i), 32'(a_value), 201);
        end
        a_rdy = 1;
        tick();
        check("bp_release_value", 32'(a_value), 264);
        tick();
        check("bp_next_value", 32'(a_value), 329);

        // Small range: rejection sampling and counter saturation at 3.
        b_sl = 1; b_seed = 10'd7; b_en = 0; b_rdy = 0;
        tick();
        check("b_load_valid", 32'(b_valid), 0);
        b_sl = 0; b_en = 1; b_rdy = 1;
        for (int i = 0; i < 9; i++) begin
            tick();
            check($sformatf("b_e%0d_valid", i + 1), 32'(b_valid), 32'(b_exp_valid[i]));
            check($sformatf("b_e%0d_value", i + 1), 32'(b_value), 32'(b_exp_value[i]));
            check($sformatf("b_e%0d_rej",   i + 1), 32'(b_rej),   32'(b_exp_rej[i]));
        end

        // Asynchronous reset mid-cycle clears state without a clock edge.
        #3;
        reset = 1'b1;
        #1;
        check("async_a_valid", 32'(a_valid), 0);
        check("async_b_rej",   32'(b_rej),   0);
        check("async_b_value", 32'(b_value), 0);
        #1;
        reset = 1'b0;
        b_en = 0;

        // Zero seed load.
        tick();
        a_sl = 1; a_seed = 10'd0; a_en = 0; a_rdy = 0;
        tick();
        check("zero_load_valid", 32'(a_valid), 0);
`ifdef RNG_ZERO_GUARD_EN
        check("zero_seed_err_pulse", 32'(a_serr), 1);
`endif
        a_sl = 0; a_en = 1; a_rdy = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("zero%0d_valid", i), 32'(a_valid), 1);
`ifdef RNG_ZERO_GUARD_EN
            check($sformatf("zero%0d_seed_err", i), 32'(a_serr), 0);
            check($sformatf("zero%0d_value", i), 32'(a_value), 32'(201 + ((1 << i) - 1)));
`else
            check($sformatf("zero%0d_value", i), 32'(a_value), 200);
`endif
            check($sformatf("zero%0d_rej", i), 32'(a_rej), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rng_ranged.md
# rng_ranged

Parametrised LFSR random-number source with an exact output range, valid/ready handshake, runtime reseed and rejection statistics. It is the next-generation replacement for the fixed 10-bit, offset-only random generator that drives game timing delays. Consumers pull uniformly distributed values in [MIN_VALUE, MAX_VALUE] through a one-deep output register. Out-of-range draws are discarded by rejection sampling, so the range no longer has to be a power of two.

## Interface
- WIDTH, 10: LFSR length in bits, 4..32.
- TAPS, 10'h240: feedback mask. Bit i set means lfsr[i] (0-indexed) is XORed into the feedback. The default is x^10+x^7+1.
- SEED, 1: reset and guard value. Must be nonzero and less than 2^WIDTH.
- MIN_VALUE, 200: lowest output value.
- MAX_VALUE, 1223: highest output value. Must be at least MIN_VALUE.
- REJ_W, 16: width of the rejection counter.
- Derived values:
  - RANGE = MAX_VALUE-MIN_VALUE+1.
  - RBITS = max(1, $clog2(RANGE)), which must be no greater than WIDTH.
  - OW = $clog2(MAX_VALUE+1).
- Ports (all inputs are synchronous to clk):
  - clk, input, 1: rising-edge clock.
  - reset, input, 1: asynchronous, active-high reset.
  - enable, input, 1: advance the generator. When low, the LFSR, output register and counter hold.
  - seed_load, input, 1: load seed_in into the LFSR.
  - seed_in, input, WIDTH: new seed.
  - out_ready, input, 1: consumer accepts out_value.
  - out_valid, output, 1: out_value holds an unconsumed value.
  - out_value, output, OW: random value in [MIN_VALUE, MAX_VALUE].
  - reject_cnt, output, REJ_W: saturating count of rejected draws.
  - seed_err, output, 1: one-cycle pulse when a zero seed is substituted. Only present with the guard macro.

## Operation
- The LFSR is a Fibonacci register that shifts toward the MSB:
  - fb = ^(lfsr & TAPS).
  - next = {lfsr[WIDTH-2:0], fb}.
- Draw: cand = lfsr[RBITS-1:0]. The draw is accepted when cand < RANGE.
- Slot free: free = !out_valid || out_ready.
- On each rising edge, the first matching rule applies:
  1. reset is high (asynchronous): lfsr=SEED, out_valid=0, out_value=0, reject_cnt=0, seed_err=0.
  2. seed_load: lfsr = seed_in, subject to the zero guard. out_valid=0, which drops any held value. reject_cnt holds. This rule does not require enable.
  3. enable=0: all state holds. An out_ready handshake is still honoured: if out_valid && out_ready, then out_valid=0.
  4. enable=1:
     - lfsr=next every cycle.
     - If free and accepted: out_value = cand+MIN_VALUE (computed at OW bits, no overflow by construction) and out_valid=1.
     - If free and rejected: out_valid=0 when out_ready consumed the old value; otherwise out_valid is unchanged. reject_cnt increments, saturating at 2^REJ_W-1.
     - If not free: out_value and out_valid hold. The draw is neither used nor counted.
- While out_valid=1 and out_ready=0, out_value is stable.
- The LFSR free-runs while enabled, even during backpressure, so consecutive outputs are not consecutive LFSR states.

## Timing
- Outputs are registered. There are no combinational paths from inputs to outputs.
- Latency:
  - First value: out_valid rises on the first enabled edge after reset release with an accepted draw.
  - Throughput: one value per cycle with out_ready held high and no rejections.
- A handshake (out_valid && out_ready) together with an accepted draw reloads out_value in the same edge. out_valid stays high with no bubble.
- seed_load takes effect on its edge. The first draw from the new seed is evaluated on the following enabled edge.
- If reset is asserted mid-stream, the held value is lost immediately, without waiting for clk.

## Configuration
- RNG_ZERO_GUARD_EN defined:
  - seed_load with seed_in==0 loads SEED instead and pulses seed_err high for one cycle.
  - The LFSR can never reach all-zero.
- RNG_ZERO_GUARD_EN undefined:
  - seed_in is loaded verbatim and the seed_err port is absent.
  - A zero seed locks the LFSR at zero. Output is then MIN_VALUE forever. If RANGE leaves cand=0 accepted, rejections are never counted.

## Test plan
- Defaults, release reset with enable=1 and out_ready=1: out_value sequence 201, 202, 204, 208 on four consecutive cycles. out_valid is high from the first edge. reject_cnt stays 0.
- Defaults, out_ready=0 for 5 cycles after the first value: out_value holds 201 and out_valid holds 1. When out_ready is raised, the next value equals lfsr+200 at that edge.
- MIN_VALUE=0, MAX_VALUE=4, seed_load with seed_in=7, then enable:
  - Draws 7 and 6 are rejected.
  - On the third edge, out_value=4, out_valid=1 and reject_cnt=2.
- REJ_W=2 with a continually rejecting configuration: reject_cnt saturates at 3 and does not wrap.
- Assert seed_load while out_valid=1: out_valid=0 on the next edge. The next output is derived from seed_in.
- seed_in=0:
  - With RNG_ZERO_GUARD_EN: lfsr=SEED, seed_err pulses once, and outputs match the post-reset sequence.
  - Without the macro: out_value is stuck at MIN_VALUE.
- Assert reset asynchronously mid-stream: out_valid=0 and reject_cnt=0 before the next clk edge.
